btn_uart_scheduler: RTL and testbench

BTN_UART_SCHEDULER -- requirements
Module: btn_uart_scheduler

---
 rtl/btn_uart_scheduler.sv | 122 ++++++++++++
 tb/tb_btn_uart_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_uart_scheduler.sv
// Round-robin scheduler that turns debounced button presses into UART characters.
// Optional feature: define BTN_SCHED_CRLF_EN to follow each character with CR and LF.
module btn_uart_scheduler #(
   parameter int unsigned NUM_BTN   = 4,
   parameter logic [7:0]  BASE_CHAR = 8'h30
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_BTN-1:0] i_btn_pulse,
   input  logic               i_ovr_clr,
   input  logic               i_tx_ready,
   output logic               o_tx_valid,
   output logic [7:0]         o_tx_data,
   output logic               o_busy,
   output logic [NUM_BTN-1:0] o_overrun
);

   localparam int unsigned IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

`ifdef BTN_SCHED_CRLF_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SEND_CHAR, ST_SEND_CR, ST_SEND_LF} state_t;
`else
   typedef enum logic [0:0] {ST_IDLE, ST_SEND_CHAR} state_t;
`endif

   state_t             r_state;
   logic [NUM_BTN-1:0] r_pending;
   logic [NUM_BTN-1:0] r_overrun;
   logic [IW-1:0]      r_last_grant;
   logic               r_tx_valid;
   logic [7:0]         r_tx_data;

   logic               w_found;
   logic [IW-1:0]      w_idx;
   logic [IW-1:0]      w_cand;
   logic [31:0]        w_j;
   logic               w_grant;
   logic [NUM_BTN-1:0] w_clr;
   logic [NUM_BTN-1:0] w_ovr_set;
   logic [NUM_BTN-1:0] w_pend_nxt;

   // Search starts just after the last granted button and wraps around.
   always_comb begin
      w_found = 1'b0;
      w_idx   = r_last_grant;
      w_j     = '0;
      w_cand  = '0;
      for (int unsigned i = 1; i <= NUM_BTN; i++) begin
         w_j    = (32'(r_last_grant) + i) % NUM_BTN;
         w_cand = IW'(w_j);
         if (!w_found && r_pending[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   assign w_grant    = (r_state == ST_IDLE) && w_found;
   assign w_clr      = w_grant ? (NUM_BTN'(1) << w_idx) : '0;
   // A press on the button being granted re-arms it instead of overrunning.
   assign w_ovr_set  = i_btn_pulse & r_pending & ~w_clr;
   assign w_pend_nxt = (r_pending & ~w_clr) | i_btn_pulse;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_pending    <= '0;
         r_overrun    <= '0;
         r_last_grant <= IW'(NUM_BTN - 1);
         r_tx_valid   <= 1'b0;
         r_tx_data    <= 8'h00;
      end else begin
         r_pending <= w_pend_nxt;
         r_overrun <= i_ovr_clr ? w_ovr_set : (r_overrun | w_ovr_set);
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_last_grant <= w_idx;
                  r_tx_data    <= BASE_CHAR + 8'(w_idx);
                  r_tx_valid   <= 1'b1;
                  r_state      <= ST_SEND_CHAR;
               end
            end
            ST_SEND_CHAR: begin
               if (i_tx_ready) begin
`ifdef BTN_SCHED_CRLF_EN
                  r_tx_data <= 8'h0D;
                  r_state   <= ST_SEND_CR;
`else
                  r_tx_valid <= 1'b0;
                  r_state    <= ST_IDLE;
`endif
               end
            end
`ifdef BTN_SCHED_CRLF_EN
            ST_SEND_CR: begin
               if (i_tx_ready) begin
                  r_tx_data <= 8'h0A;
                  r_state   <= ST_SEND_LF;
               end
            end
            ST_SEND_LF: begin
               if (i_tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
`endif
            default: begin
               r_tx_valid <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_tx_valid = r_tx_valid;
   assign o_tx_data  = r_tx_data;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_btn_uart_scheduler.sv
// Directed bench for btn_uart_scheduler: arbitration order, handshake stall, overrun, reset abort.
module tb_btn_uart_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic       ovr_clr;
   logic       ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       busy;
   logic [3:0] overrun;

   int n_vec;
   int n_err;

   btn_uart_scheduler #(
      .NUM_BTN   (4),
      .BASE_CHAR (8'h30)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_btn_pulse (btn),
      .i_ovr_clr   (ovr_clr),
      .i_tx_ready  (ready),
      .o_tx_valid  (tx_valid),
      .o_tx_data   (tx_data),
      .o_busy      (busy),
      .o_overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag, input logic [7:0] d);
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(d));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Character byte is assumed transferred on the next edge; checks CR/LF when enabled.
   task automatic drain_tail(input string tag);
`ifdef BTN_SCHED_CRLF_EN
      tick();
      chk_byte({tag, "_cr"}, 8'h0D);
      tick();
      chk_byte({tag, "_lf"}, 8'h0A);
`else
      chk({tag, "_tail"}, 32'(tx_valid), 32'd1);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      btn     = '0;
      ovr_clr = 1'b0;
      ready   = 1'b1;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      // Single press on button 2: two-cycle latency
      btn = 4'b0100;
      tick();
      btn = '0;
      chk_idle("b2_lat1");
      tick();
      chk_byte("b2", 8'h32);
      drain_tail("b2");
      tick();
      chk_idle("b2_done");
      tick();
      chk_idle("b2_quiet");

      // Round robin from reset priority
      do_reset();
      btn = 4'b1011;
      tick();
      btn = '0;
      tick();
      chk_byte("rr_a", 8'h30);
      drain_tail("rr_a");
      tick();
      chk_idle("rr_a_gap");
      tick();
      chk_byte("rr_b", 8'h31);
      drain_tail("rr_b");
      tick();
      chk_idle("rr_b_gap");
      tick();
      chk_byte("rr_c", 8'h33);
      drain_tail("rr_c");
      tick();
      chk_idle("rr_c_gap");
      btn = 4'b0011;
      tick();
      btn = '0;
      tick();
      chk_byte("rr_d", 8'h30);
      drain_tail("rr_d");
      tick();
      chk_idle("rr_d_gap");
      tick();
      chk_byte("rr_e", 8'h31);
      drain_tail("rr_e");
      tick();
      chk_idle("rr_e_gap");

      // Backpressure: 20 cycles without ready
      ready = 1'b0;
      btn   = 4'b1000;
      tick();
      btn = '0;
      tick();
      chk_byte("stall_start", 8'h33);
      for (int c = 0; c < 20; c++) begin
         tick();
         chk_byte("stall_hold", 8'h33);
      end
      ready = 1'b1;
      drain_tail("stall");
      tick();
      chk_idle("stall_done");

      // Overrun on button 1 while its first press waits
      ready = 1'b0;
      btn   = 4'b0001;
      tick();
      btn = '0;
      tick();
      chk_byte("ovr_hold0", 8'h30);
      btn = 4'b0010;
      tick();
      chk("ovr_first", 32'(overrun), 32'h0);
      tick();
      btn = '0;
      chk("ovr_second", 32'(overrun), 32'h2);
      chk_byte("ovr_hold1", 8'h30);
      ready = 1'b1;
      drain_tail("ovr_30");
      tick();
      chk_idle("ovr_gap");
      tick();
      chk_byte("ovr_31", 8'h31);
      drain_tail("ovr_31");
      tick();
      chk_idle("ovr_end");
      tick();
      chk_idle("ovr_single");
      chk("ovr_sticky", 32'(overrun), 32'h2);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'h0);

      // Press in the grant cycle of the same button re-arms it
      btn = 4'b0001;
      tick();
      tick();
      btn = '0;
      chk_byte("rearm_a", 8'h30);
      chk("rearm_ovr", 32'(overrun), 32'h0);
      drain_tail("rearm_a");
      tick();
      chk_idle("rearm_gap");
      tick();
      chk_byte("rearm_b", 8'h30);
      drain_tail("rearm_b");
      tick();
      chk_idle("rearm_end");
      tick();
      chk_idle("rearm_quiet");
      chk("rearm_ovr2", 32'(overrun), 32'h0);

      // Clear vs new overrun, then reset mid-message with pending bits
      ready = 1'b0;
      btn   = 4'b1000;
      tick();
      btn = '0;
      tick();
      chk_byte("abort_hold", 8'h33);
      btn = 4'b0100;
      tick();
      tick();
      chk("ovr_b2", 32'(overrun), 32'h4);
      btn = 4'b0010;
      tick();
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      btn     = '0;
      chk("ovr_clr_set", 32'(overrun), 32'h2);
      rst = 1'b1;
      btn = 4'b0001;
      tick();
      rst   = 1'b0;
      btn   = '0;
      ready = 1'b1;
      chk_idle("abort");
      chk("abort_data", 32'(tx_data), 32'h00);
      chk("abort_ovr", 32'(overrun), 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_idle("abort_quiet");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
